// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sample width, frame
// length and the framer read-side state encoding.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  // Slot index of the final sample in a frame.
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  // Read-side (FFT-facing) controller states.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_WAIT  = 2'd2
  } rd_state_e;

  // Packed complex sample as stored in a bank.
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry complex sample register bank: indexed single-entry write,
// full-width parallel read-out. Contents clear to zero on reset.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [LOG2N-1:0]  idx_i,
  input  logic [DATA_W-1:0] wr_real_i,
  input  logic [DATA_W-1:0] wr_imag_i,
  output logic [DATA_W-1:0] rd_real_o [N-1:0],
  output logic [DATA_W-1:0] rd_imag_o [N-1:0]
);

  logic [DATA_W-1:0] real_q [N-1:0];
  logic [DATA_W-1:0] imag_q [N-1:0];

  // Store one sample into the addressed slot; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        real_q[i] <= '0;
        imag_q[i] <= '0;
      end
    end else if (we_i) begin
      real_q[idx_i] <= wr_real_i;
      imag_q[idx_i] <= wr_imag_i;
    end
  end

  // Whole bank is visible in parallel.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_real_o[i] = real_q[i];
      rd_imag_o[i] = imag_q[i];
    end
  end

endmodule

// File: rtl/fft_8_input_framer.sv
// Serial-to-frame feeder for the 8-point FFT. Samples arrive over a
// valid/ready stream and are packed into one of two banks (ping-pong).
// A full bank is presented to the FFT with a one-cycle start pulse and
// held until the FFT signals done, while the other bank keeps filling.
//
// Handshake: a sample transfers on a rising edge where s_valid and s_ready
// are both high. s_ready depends only on registered full flags, so it never
// combinationally follows s_valid or fft_done. The source may hold s_valid
// with stable data for any number of cycles until the transfer happens.
module fft_8_input_framer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  input  logic              s_last,
  output logic [DATA_W-1:0] frame_real [N-1:0],
  output logic [DATA_W-1:0] frame_imag [N-1:0],
  output logic              fft_start,
  input  logic              fft_done,
  output logic              sync_err,
  output logic [15:0]       frame_cnt,
  output rd_state_e         dbg_rd_state
);

  // Write-side pointers and per-bank full flags.
  logic             wr_bank_q;
  logic [LOG2N-1:0] wr_idx_q;
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             sync_err_q;

  // Read-side controller registers.
  rd_state_e        state_q;
  logic             rd_bank_q;
  logic             fft_start_q;
  logic [15:0]      frame_cnt_q;

  // Decoded events for this cycle.
  logic accept;
  logic last_slot;
  logic bad_last;
  logic do_write;
  logic frame_fill;
  logic frame_release;

  assign s_ready       = !full_q[wr_bank_q];
  assign accept        = s_valid && s_ready;
  assign last_slot     = (wr_idx_q == LAST_IDX);
  // A frame marker that lands before the last slot aborts the partial frame.
  assign bad_last      = accept && s_last && !last_slot;
  assign do_write      = accept && !bad_last;
  assign frame_fill    = accept && last_slot;
  assign frame_release = (state_q == R_WAIT) && fft_done;

  // Two banks; only the bank under the write pointer takes the sample.
  logic [DATA_W-1:0] b0_real [N-1:0];
  logic [DATA_W-1:0] b0_imag [N-1:0];
  logic [DATA_W-1:0] b1_real [N-1:0];
  logic [DATA_W-1:0] b1_imag [N-1:0];

  fft_frame_bank u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (do_write && !wr_bank_q),
    .idx_i     (wr_idx_q),
    .wr_real_i (s_real),
    .wr_imag_i (s_imag),
    .rd_real_o (b0_real),
    .rd_imag_o (b0_imag)
  );

  fft_frame_bank u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (do_write && wr_bank_q),
    .idx_i     (wr_idx_q),
    .wr_real_i (s_real),
    .wr_imag_i (s_imag),
    .rd_real_o (b1_real),
    .rd_imag_o (b1_imag)
  );

  // Next full flags: fill and release can coincide, but never on one bank,
  // because a full read bank blocks writes to itself.
  always_comb begin
    full_d = full_q;
    if (frame_fill) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (frame_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Write pointer, bank toggle on the eighth sample, sticky framing error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= 2'b00;
      sync_err_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (frame_fill) begin
        wr_idx_q  <= '0;
        wr_bank_q <= !wr_bank_q;
      end else if (bad_last) begin
        wr_idx_q   <= '0;
        sync_err_q <= 1'b1;
      end else if (accept) begin
        wr_idx_q <= wr_idx_q + LOG2N'(1);
      end
    end
  end

  // Read controller: present the read bank, pulse start, wait for done.
  // Idle looks at the next-state full flag so start follows the last
  // accept by one cycle; after a release it passes through idle once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= R_IDLE;
      rd_bank_q   <= 1'b0;
      fft_start_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        R_IDLE: begin
          fft_start_q <= 1'b0;
          if (full_d[rd_bank_q]) begin
            state_q     <= R_START;
            fft_start_q <= 1'b1;
          end
        end
        R_START: begin
          fft_start_q <= 1'b0;
          state_q     <= R_WAIT;
        end
        R_WAIT: begin
          fft_start_q <= 1'b0;
          if (fft_done) begin
            rd_bank_q   <= !rd_bank_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= R_IDLE;
          end
        end
        default: begin
          fft_start_q <= 1'b0;
          state_q     <= R_IDLE;
        end
      endcase
    end
  end

  // Frame output follows the read pointer; that bank cannot be written
  // while it is full, so the data is stable for the whole FFT run.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      frame_real[i] = rd_bank_q ? b1_real[i] : b0_real[i];
      frame_imag[i] = rd_bank_q ? b1_imag[i] : b0_imag[i];
    end
  end

  assign fft_start    = fft_start_q;
  assign sync_err     = sync_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign dbg_rd_state = state_q;

endmodule

// File: tb/tb_fft_8_input_framer.sv
// Bench for fft_8_input_framer: directed scenarios plus random streaming,
// checked every cycle against a frame-level reference model.
module tb_fft_8_input_framer;
  import fft_pkg::*;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              s_last;
  logic [DATA_W-1:0] frame_real [N-1:0];
  logic [DATA_W-1:0] frame_imag [N-1:0];
  logic              fft_start;
  logic              fft_done;
  logic              sync_err;
  logic [15:0]       frame_cnt;
  rd_state_e         dbg_rd_state;

  fft_8_input_framer dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_real       (s_real),
    .s_imag       (s_imag),
    .s_last       (s_last),
    .frame_real   (frame_real),
    .frame_imag   (frame_imag),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .sync_err     (sync_err),
    .frame_cnt    (frame_cnt),
    .dbg_rd_state (dbg_rd_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds completed frames not yet released by the FFT, oldest first;
  // each entry packs sample k as {re, im} at bits [k*32 +: 32].
  logic [2*DATA_W*N-1:0] exp_q [$];
  logic [2*DATA_W-1:0]   part_q [$];
  bit                    presenting = 0;
  int                    start_at   = 0;
  int                    cyc        = 0;
  logic                  m_sync_err = 0;
  logic [15:0]           m_cnt      = 0;
  bit                    chk_en     = 0;

  always @(posedge clk) begin
    bit m_ready;
    bit rel;
    logic [2*DATA_W*N-1:0] fr;
    if (rst) begin
      m_ready = (exp_q.size() < 2);
      cyc++;
      // Done counts only once the start pulse cycle has passed.
      rel = presenting && (cyc >= start_at + 2) && fft_done;
      if (rel) begin
        void'(exp_q.pop_front());
        m_cnt++;
        presenting = 0;
      end
      if (s_valid && m_ready) begin
        if (s_last && part_q.size() != N - 1) begin
          part_q.delete();
          m_sync_err = 1'b1;
        end else begin
          part_q.push_back({s_real, s_imag});
          if (part_q.size() == N) begin
            for (int k = 0; k < N; k++) fr[k*32 +: 32] = part_q[k];
            exp_q.push_back(fr);
            part_q.delete();
          end
        end
      end
      // A waiting frame starts right after its fill, or one idle cycle after a release.
      if (!presenting && exp_q.size() > 0) begin
        start_at   = rel ? cyc + 1 : cyc;
        presenting = 1;
      end
    end
  end

  // Scoreboard: compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check_eq("s_ready", s_ready, exp_q.size() < 2);
      check_eq("fft_start", fft_start, presenting && (start_at == cyc));
      check_eq("sync_err", sync_err, m_sync_err);
      check_eq("frame_cnt", frame_cnt, m_cnt);
      if (presenting && cyc >= start_at) begin
        for (int k = 0; k < N; k++) begin
          check_eq($sformatf("frame_real[%0d]", k), frame_real[k], exp_q[0][k*32+16 +: 16]);
          check_eq($sformatf("frame_imag[%0d]", k), frame_imag[k], exp_q[0][k*32 +: 16]);
        end
      end
    end
  end

  // ---------------- FFT responder ----------------
  bit   auto_fft = 1;
  int   done_lat = 3;
  int   dl_cnt   = 0;
  logic auto_done = 0;
  logic man_done  = 0;
  assign fft_done = auto_done | man_done;

  always @(negedge clk) begin
    if (!rst) begin
      dl_cnt    = 0;
      auto_done = 1'b0;
    end else begin
      auto_done = 1'b0;
      if (auto_fft && fft_start) begin
        dl_cnt = done_lat;
      end else if (dl_cnt > 0) begin
        dl_cnt--;
        if (dl_cnt == 0) auto_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    int guard = 0;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = last;
    while (!s_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check_eq("send_timeout", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_fft_start", fft_start, 1'b0);
    check_eq("rst_sync_err", sync_err, 1'b0);
    check_eq("rst_frame_cnt", frame_cnt, 16'd0);
    check_eq("rst_state", dbg_rd_state, R_IDLE);
    for (int k = 0; k < N; k++) begin
      check_eq("rst_frame_real", frame_real[k], 16'd0);
      check_eq("rst_frame_imag", frame_imag[k], 16'd0);
    end
  endtask

  // Asserts reset off the clock edge, checks outputs at once, releases later.
  task automatic apply_reset();
    #2;
    rst      = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    man_done = 1'b0;
    exp_q.delete();
    part_q.delete();
    presenting = 0;
    m_sync_err = 1'b0;
    m_cnt      = 16'd0;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || presenting) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check_eq("idle_timeout", dbg_rd_state, R_IDLE);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame_rand(input logic last_on_8th);
    for (int k = 0; k < N; k++) begin
      send(16'($urandom), 16'($urandom), (k == N - 1) ? last_on_8th : 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] saved_cnt;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    s_last  = 1'b0;
    #3;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    chk_en = 1;
    @(negedge clk);

    // Directed frame 1..8 / 0x10..0x80.
    done_lat = 5;
    for (int k = 0; k < N; k++) begin
      send(16'(k + 1), 16'((k + 1) * 16), (k == N - 1));
    end
    check_eq("first_frame_real0", frame_real[0], 16'd1);
    check_eq("first_frame_real7", frame_real[7], 16'd8);
    check_eq("first_frame_imag7", frame_imag[7], 16'h0080);
    wait_idle();
    check_eq("first_frame_cnt", frame_cnt, 16'd1);

    // 24 back-to-back samples with a slow FFT: both banks fill, stall, resume.
    done_lat = 40;
    for (int f = 0; f < 3; f++) send_frame_rand(1'b1);
    wait_idle();
    check_eq("stream24_cnt", frame_cnt, 16'd4);

    // Early frame marker on the 5th sample, then a clean frame.
    done_lat = 3;
    for (int k = 0; k < 5; k++) send(16'h0A00 + 16'(k), 16'h0B00, (k == 4));
    check_eq("early_last_sync_err", sync_err, 1'b1);
    check_eq("early_last_no_start", dbg_rd_state, R_IDLE);
    for (int k = 0; k < N; k++) send(16'h0C00 + 16'(k), 16'h0D00 + 16'(k), (k == N - 1));
    check_eq("post_err_real0", frame_real[0], 16'h0C00);
    wait_idle();

    // Done asserted during idle and start must be ignored.
    auto_fft  = 0;
    saved_cnt = frame_cnt;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) man_done = 1'b1;
      send(16'($urandom), 16'($urandom), 1'b0);
    end
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("spurious_done_cnt", frame_cnt, saved_cnt);
    check_eq("spurious_done_state", dbg_rd_state, R_WAIT);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check_eq("manual_done_cnt", frame_cnt, saved_cnt + 16'd1);

    // Reset four samples into a frame.
    auto_fft = 1;
    for (int k = 0; k < 4; k++) send(16'($urandom), 16'($urandom), 1'b0);
    apply_reset();
    @(negedge clk);
    send_frame_rand(1'b1);
    wait_idle();
    check_eq("after_rst_cnt", frame_cnt, 16'd1);

    // Reset while the start pulse is high.
    auto_fft = 0;
    send_frame_rand(1'b1);
    check_eq("start_before_rst", fft_start, 1'b1);
    apply_reset();

    // Reset while waiting for done.
    @(negedge clk);
    send_frame_rand(1'b0);
    repeat (3) @(negedge clk);
    check_eq("wait_before_rst", dbg_rd_state, R_WAIT);
    apply_reset();
    auto_fft = 1;
    @(negedge clk);
    send_frame_rand(1'b1);
    wait_idle();
    check_eq("after_wait_rst_cnt", frame_cnt, 16'd1);

    // Counter wrap: preload near the top and release two frames.
    #2;
    m_cnt = 16'hFFFE;
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    #2;
    release dut.frame_cnt_q;
    @(negedge clk);
    send_frame_rand(1'b1);
    send_frame_rand(1'b1);
    wait_idle();
    check_eq("cnt_wrap", frame_cnt, 16'd0);

    // Random streaming with gaps, varied FFT latency, occasional aborts.
    for (int f = 0; f < 24; f++) begin
      done_lat = $urandom_range(1, 12);
      for (int k = 0; k < N; k++) begin
        bit abort;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        abort = (k > 0) && (k < N - 1) && ($urandom_range(0, 15) == 0);
        send(16'($urandom), 16'($urandom), abort ? 1'b1 : ((k == N - 1) ? 1'($urandom_range(0, 1)) : 1'b0));
        if (abort) break;
      end
    end
    wait_idle();
    check_eq("final_s_ready", s_ready, 1'b1);
    check_eq("final_state", dbg_rd_state, R_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #600000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish by t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
